// File: rtl/pc_fetch_redirect.sv
// IF-stage PC owner: drives the imem request handshake, absorbs EXE redirects and
// flushes younger stages. Optional macro REDIRECT_ALIGN_CHECK_EN rejects misaligned targets.
module pc_fetch_redirect #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_src_exe,
  input  logic [ADDR_WIDTH-1:0] pc_target_exe,
  input  logic                  stall_if,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_rdata,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [ADDR_WIDTH-1:0] pc_if,
  output logic [ADDR_WIDTH-1:0] pc_plus4_if,
  output logic [31:0]           instr_if,
  output logic                  instr_valid_if,
  output logic                  flush_id,
  output logic                  flush_exe
`ifdef REDIRECT_ALIGN_CHECK_EN
  ,
  output logic                  misalign_err,
  output logic [ADDR_WIDTH-1:0] misalign_addr
`endif
);

  typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [ADDR_WIDTH-1:0] pending_q;
  logic [ADDR_WIDTH-1:0] hold_pc_q;
  logic [31:0]           hold_instr_q;
  logic                  outstanding_q;
  logic                  redirect_req;
  logic                  redirect;
  logic                  accept;
  logic                  waiting;
  logic [ADDR_WIDTH-1:0] target;

  // X/Z on pc_src_exe must never be taken as a redirect, hence the case equality.
  assign redirect_req = rst && (pc_src_exe === 1'b1);

`ifdef REDIRECT_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (pc_target_exe[1:0] != 2'b00);
  assign redirect   = redirect_req && !misaligned;
  assign target     = pc_target_exe;
`else
  assign redirect   = redirect_req;
  assign target     = pc_target_exe & ~ADDR_WIDTH'(3);
`endif

  assign accept      = imem_req && imem_ready;
  assign waiting     = imem_req && !imem_ready;
  assign imem_addr   = fetch_pc_q;
  assign pc_plus4_if = pc_if + ADDR_WIDTH'(4);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (redirect && waiting)               state_d = DRAIN;
        else if (!redirect && accept && stall_if) state_d = HOLD;
      end
      DRAIN:   if (accept) state_d = FETCH;
      HOLD:    if (redirect || !stall_if) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    imem_req  = 1'b0;
    flush_id  = redirect;
    flush_exe = redirect;
    if (rst) begin
      case (state_q)
        FETCH:   imem_req = !stall_if || outstanding_q;
        DRAIN:   imem_req = 1'b1;
        default: imem_req = 1'b0;
      endcase
    end
  end

  // NOTE: the hold buffer is not reset; it is always written before HOLD reads it.
  always_ff @(posedge clk) begin
    if (state_q == FETCH && accept && stall_if && !redirect) begin
      hold_instr_q <= imem_rdata;
      hold_pc_q    <= fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q     <= RESET_VECTOR;
      pending_q      <= RESET_VECTOR;
      outstanding_q  <= 1'b0;
      pc_if          <= RESET_VECTOR;
      instr_if       <= '0;
      instr_valid_if <= 1'b0;
    end else begin
      outstanding_q <= waiting;
      case (state_q)
        FETCH: begin
          if (redirect) begin
            instr_valid_if <= 1'b0;
            if (waiting) pending_q  <= target;
            else         fetch_pc_q <= target;
          end else if (accept) begin
            fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(4);
            if (!stall_if) begin
              instr_if       <= imem_rdata;
              pc_if          <= fetch_pc_q;
              instr_valid_if <= 1'b1;
            end
          end else if (!stall_if) begin
            instr_valid_if <= 1'b0;
          end
        end
        DRAIN: begin
          // Address stays put until the abandoned word is accepted and thrown away.
          instr_valid_if <= 1'b0;
          if (redirect) pending_q <= target;
          if (accept)   fetch_pc_q <= redirect ? target : pending_q;
        end
        HOLD: begin
          if (redirect) begin
            fetch_pc_q     <= target;
            instr_valid_if <= 1'b0;
          end else if (!stall_if) begin
            instr_if       <= hold_instr_q;
            pc_if          <= hold_pc_q;
            instr_valid_if <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REDIRECT_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign_err <= redirect_req && misaligned;
      if (redirect_req && misaligned) misalign_addr <= pc_target_exe;
    end
  end
`endif

endmodule
